// File: rtl/bsg_dmc_pkg.sv
// Shared types and command encodings for the bsg_dmc app-port arbiter.
package bsg_dmc_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WDATA} arb_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WP = 3'b010;
  localparam logic [2:0] CMD_RP = 3'b011;
  localparam int         RD_BIT = 0;

  // Encodings 1xx are not defined by the controller and are handled as RP.
  function automatic logic is_read(input logic [2:0] c);
    return c[RD_BIT] | c[2];
  endfunction

  function automatic logic [2:0] app_cmd(input logic [2:0] c);
    return c[2] ? CMD_RP : c;
  endfunction

endpackage

// File: rtl/bsg_dmc_app_arbiter_if.sv
// Controller-facing app_* bundle; master side is the arbiter, slave side the controller.
interface bsg_dmc_app_arbiter_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic [addr_width_p-1:0]   addr;
  logic [2:0]                cmd;
  logic                      en;
  logic                      rdy;
  logic [data_width_p-1:0]   wdf_data;
  logic [data_width_p/8-1:0] wdf_mask;
  logic                      wdf_wren;
  logic                      wdf_end;
  logic                      wdf_rdy;
  logic [data_width_p-1:0]   rd_data;
  logic                      rd_data_valid;
  logic                      rd_data_end;

  modport master (
    output addr, cmd, en, wdf_data, wdf_mask, wdf_wren, wdf_end,
    input  rdy, wdf_rdy, rd_data, rd_data_valid, rd_data_end
  );

  modport slave (
    input  addr, cmd, en, wdf_data, wdf_mask, wdf_wren, wdf_end,
    output rdy, wdf_rdy, rd_data, rd_data_valid, rd_data_end
  );
endinterface

// File: rtl/bsg_dmc_rd_tag_fifo.sv
// In-order FIFO of requester tags for outstanding read bursts.
module bsg_dmc_rd_tag_fifo #(
  parameter int tag_width_p = 1,
  parameter int depth_p     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [tag_width_p-1:0] tag_in,
  input  logic                   pop,
  output logic [tag_width_p-1:0] tag_out,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = (depth_p > 1) ? $clog2(depth_p) : 1;

  logic [tag_width_p-1:0] mem [depth_p];
  logic [AW:0]            wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tag_out = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= tag_in;
  end
endmodule

// File: rtl/bsg_dmc_app_arbiter.sv
// Round-robin sharing of one bsg_dmc app port; writes hold the grant for their
// whole data burst, read bursts are steered back through an in-order tag FIFO.
module bsg_dmc_app_arbiter
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int ui_addr_width_p   = 28,
  parameter int ui_data_width_p   = 64,
  parameter int ui_burst_length_p = 8,
  parameter int rd_tag_depth_p    = 4
) (
  input  logic                                          ui_clk_i,
  input  logic                                          ui_reset_i,
  input  logic [num_req_p-1:0]                          req_v_i,
  input  logic [num_req_p-1:0][2:0]                     req_cmd_i,
  input  logic [num_req_p-1:0][ui_addr_width_p-1:0]     req_addr_i,
  output logic [num_req_p-1:0]                          req_ready_o,
  input  logic [num_req_p-1:0]                          req_wdata_v_i,
  input  logic [num_req_p-1:0][ui_data_width_p-1:0]     req_wdata_i,
  input  logic [num_req_p-1:0][ui_data_width_p/8-1:0]   req_wmask_i,
  output logic [num_req_p-1:0]                          req_wdata_ready_o,
  output logic [num_req_p-1:0]                          req_rdata_v_o,
  output logic [num_req_p-1:0]                          req_rdata_last_o,
  output logic [ui_data_width_p-1:0]                    req_rdata_o,
  bsg_dmc_app_arbiter_if.master                         app,
  input  logic                                          init_calib_complete_i,
  output logic                                          rd_unexpected_o
);
  localparam int GW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int BW = (ui_burst_length_p > 1) ? $clog2(ui_burst_length_p) : 1;

  arb_state_e             state, state_n;
  logic [GW-1:0]          grant, rr_ptr, pick, tag_head;
  logic [BW-1:0]          beat_cnt;
  logic [num_req_p-1:0]   elig;
  logic                   pick_v;
  int                     scan_idx;
  logic                   tag_full, tag_empty;
  logic                   cur_rd, cmd_fire, beat_fire, last_beat, rd_v;

  assign cur_rd    = is_read(req_cmd_i[grant]);
  assign cmd_fire  = (state == CMD) && app.rdy;
  assign beat_fire = (state == WDATA) && req_wdata_v_i[grant] && app.wdf_rdy;
  assign last_beat = (beat_cnt == BW'(ui_burst_length_p - 1));
  assign rd_v      = app.rd_data_valid && !tag_empty;

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_v   = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int i = 0; i < num_req_p; i++)
      elig[i] = req_v_i[i] && (!is_read(req_cmd_i[i]) || !tag_full);
    for (int k = 0; k < num_req_p; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= num_req_p) scan_idx = scan_idx - num_req_p;
      if (!pick_v && elig[scan_idx]) begin
        pick_v = 1'b1;
        pick   = scan_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (init_calib_complete_i && pick_v) state_n = CMD;
      CMD:     if (app.rdy) state_n = cur_rd ? IDLE : WDATA;
      WDATA:   if (beat_fire && last_beat) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    app.en            = 1'b0;
    app.cmd           = '0;
    app.addr          = '0;
    app.wdf_wren      = 1'b0;
    app.wdf_end       = 1'b0;
    app.wdf_data      = '0;
    app.wdf_mask      = '0;
    req_ready_o       = '0;
    req_wdata_ready_o = '0;
    req_rdata_v_o     = '0;
    req_rdata_last_o  = '0;
    if (state == CMD) begin
      app.en             = 1'b1;
      app.cmd            = app_cmd(req_cmd_i[grant]);
      app.addr           = req_addr_i[grant];
      req_ready_o[grant] = app.rdy;
    end
    if (state == WDATA) begin
      app.wdf_wren             = req_wdata_v_i[grant];
      app.wdf_end              = last_beat;
      app.wdf_data             = req_wdata_i[grant];
      app.wdf_mask             = req_wmask_i[grant];
      req_wdata_ready_o[grant] = app.wdf_rdy;
    end
    req_rdata_v_o[tag_head]    = rd_v;
    req_rdata_last_o[tag_head] = rd_v && app.rd_data_end;
  end

  // Broadcast data is forced low in reset so no output leaks the controller bus.
  assign req_rdata_o = ui_reset_i ? '0 : app.rd_data;

  always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
    if (ui_reset_i) begin
      state           <= IDLE;
      grant           <= '0;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      rd_unexpected_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == CMD) grant <= pick;
      if (cmd_fire)
        rr_ptr <= (grant == GW'(num_req_p - 1)) ? '0 : grant + GW'(1);
      if (cmd_fire && !cur_rd) beat_cnt <= '0;
      else if (beat_fire)      beat_cnt <= beat_cnt + BW'(1);
      if (app.rd_data_valid && tag_empty) rd_unexpected_o <= 1'b1;
    end
  end

  bsg_dmc_rd_tag_fifo #(
    .tag_width_p (GW),
    .depth_p     (rd_tag_depth_p)
  ) u_tag_fifo (
    .clk     (ui_clk_i),
    .rst     (ui_reset_i),
    .push    (cmd_fire && cur_rd),
    .tag_in  (grant),
    .pop     (app.rd_data_valid && app.rd_data_end),
    .tag_out (tag_head),
    .full    (tag_full),
    .empty   (tag_empty)
  );
endmodule

// File: tb/tb_bsg_dmc_app_arbiter.sv
// Directed bench for bsg_dmc_app_arbiter: reads, fairness, write stalls, tag-full, spurious data, async reset.
module tb_bsg_dmc_app_arbiter;
  import bsg_dmc_pkg::*;

  logic             clk, rst, calib, rd_unexp;
  logic [1:0]       req_v, req_ready, wdata_v, wdata_ready, rdata_v, rdata_last;
  logic [1:0][2:0]  req_cmd;
  logic [1:0][27:0] req_addr;
  logic [1:0][63:0] wdata;
  logic [1:0][7:0]  wmask;
  logic [63:0]      rdata;
  int               errors = 0;
  int               checks = 0;
  int               n;
  logic             rdy_now;

  bsg_dmc_app_arbiter_if #(.addr_width_p(28), .data_width_p(64)) app_if ();

  bsg_dmc_app_arbiter #(
    .num_req_p(2), .ui_addr_width_p(28), .ui_data_width_p(64),
    .ui_burst_length_p(8), .rd_tag_depth_p(4)
  ) dut (
    .ui_clk_i(clk), .ui_reset_i(rst),
    .req_v_i(req_v), .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .req_wdata_v_i(wdata_v), .req_wdata_i(wdata), .req_wmask_i(wmask),
    .req_wdata_ready_o(wdata_ready),
    .req_rdata_v_o(rdata_v), .req_rdata_last_o(rdata_last), .req_rdata_o(rdata),
    .app(app_if), .init_calib_complete_i(calib), .rd_unexpected_o(rd_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    req_v = '0; req_cmd = '0; req_addr = '0;
    wdata_v = '0; wdata = '0; wmask = '0;
    app_if.rdy = 1'b1; app_if.wdf_rdy = 1'b1;
    app_if.rd_data = '0; app_if.rd_data_valid = 1'b0; app_if.rd_data_end = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset state, with live traffic on the inputs
    rst = 1'b1; calib = 1'b1;
    clr_inputs();
    req_v = 2'b11; req_cmd[0] = CMD_RD; req_cmd[1] = CMD_WR;
    app_if.rd_data = 64'hDEAD_BEEF; app_if.rd_data_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_en",     app_if.en, 0);
    chk("rst_ready",  req_ready, 0);
    chk("rst_rdv",    rdata_v, 0);
    chk("rst_rdata",  rdata, 0);
    chk("rst_wren",   app_if.wdf_wren, 0);
    chk("rst_unexp",  rd_unexp, 0);

    // single read by req0, then spurious data
    do_reset();
    req_v = 2'b01; req_cmd[0] = CMD_RD; req_addr[0] = 28'h100;
    #1 chk("rd_idle_en", app_if.en, 0);
    @(negedge clk); #1;
    chk("rd_en", app_if.en, 1);
    chk("rd_cmd", app_if.cmd, 3'b001);
    chk("rd_addr", app_if.addr, 28'h100);
    chk("rd_ready", req_ready, 2'b01);
    @(negedge clk); req_v = '0;
    #1 chk("rd_en_1cyc", app_if.en, 0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      app_if.rd_data_valid = 1'b1; app_if.rd_data = 64'hA000 + 64'(b); app_if.rd_data_end = (b == 7);
      #1;
      chk("rd_v", rdata_v, 2'b01);
      chk("rd_last", rdata_last, (b == 7) ? 2'b01 : 2'b00);
      chk("rd_data", rdata, 64'hA000 + 64'(b));
    end
    @(negedge clk);
    app_if.rd_data_end = 1'b1;
    #1;
    chk("spur_v", rdata_v, 0);
    chk("spur_unexp_pre", rd_unexp, 0);
    @(negedge clk);
    app_if.rd_data_valid = 1'b0; app_if.rd_data_end = 1'b0;
    #1 chk("spur_unexp", rd_unexp, 1);
    repeat (3) @(negedge clk);
    #1 chk("spur_sticky", rd_unexp, 1);

    // fairness: both hold RD; grants alternate until the tag FIFO fills
    do_reset();
    #1 chk("unexp_cleared", rd_unexp, 0);
    req_v = 2'b11; req_cmd[0] = CMD_RD; req_cmd[1] = CMD_RD;
    req_addr[0] = 28'h200; req_addr[1] = 28'h300;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("rr_en", app_if.en, 1);
      chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_addr", app_if.addr, (k % 2 == 0) ? 28'h200 : 28'h300);
      @(negedge clk); #1;
      chk("rr_gap", app_if.en, 0);
    end
    repeat (3) begin
      @(negedge clk); #1;
      chk("full_en", app_if.en, 0);
      chk("full_ready", req_ready, 0);
    end
    // a write from req1 still gets through with the FIFO full
    @(negedge clk); req_cmd[1] = CMD_WR; req_addr[1] = 28'h400;
    #1 chk("full_wr_idle", app_if.en, 0);
    @(negedge clk); #1;
    chk("full_wr_en", app_if.en, 1);
    chk("full_wr_cmd", app_if.cmd, 3'b000);
    chk("full_wr_addr", app_if.addr, 28'h400);
    chk("full_wr_ready", req_ready, 2'b10);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      req_v = 2'b01; wdata_v = 2'b10; wdata[1] = 64'hB000 + 64'(b); wmask[1] = 8'h0F;
      #1;
      chk("full_wren", app_if.wdf_wren, 1);
      chk("full_wdata", app_if.wdf_data, 64'hB000 + 64'(b));
      chk("full_wmask", app_if.wdf_mask, 8'h0F);
      chk("full_wend", app_if.wdf_end, (b == 7));
      chk("full_wready", wdata_ready, 2'b10);
    end
    @(negedge clk); wdata_v = '0;
    #1 chk("full_after_wr", app_if.en, 0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      app_if.rd_data_valid = 1'b1; app_if.rd_data = 64'hC0 + 64'(b); app_if.rd_data_end = (b == 7);
      #1;
      chk("full_ret_v", rdata_v, 2'b01);
      chk("full_ret_last", rdata_last, (b == 7) ? 2'b01 : 2'b00);
      chk("full_ret_hold", app_if.en, 0);
    end
    @(negedge clk); app_if.rd_data_valid = 1'b0; app_if.rd_data_end = 1'b0;
    #1 chk("full_pop_idle", app_if.en, 0);
    @(negedge clk); #1;
    chk("full_5th_en", app_if.en, 1);
    chk("full_5th_ready", req_ready, 2'b01);
    chk("full_5th_addr", app_if.addr, 28'h200);

    // write burst from req1 with two wdf stalls; req0 RD waits behind it
    do_reset();
    req_v = 2'b10; req_cmd[1] = CMD_WR; req_addr[1] = 28'h500;
    #1 chk("wr_idle", app_if.en, 0);
    @(negedge clk);
    req_v = 2'b11; req_cmd[0] = CMD_RD; req_addr[0] = 28'h600;
    #1;
    chk("wr_en", app_if.en, 1);
    chk("wr_addr", app_if.addr, 28'h500);
    chk("wr_ready", req_ready, 2'b10);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy_now = !(c == 2 || c == 6);
      wdata_v = 2'b10; wdata[1] = 64'hD000 + 64'(n); app_if.wdf_rdy = rdy_now;
      #1;
      chk("wr_wren", app_if.wdf_wren, 1);
      chk("wr_wready", wdata_ready, rdy_now ? 2'b10 : 2'b00);
      chk("wr_end", app_if.wdf_end, (n == 7));
      chk("wr_data", app_if.wdf_data, 64'hD000 + 64'(n));
      chk("wr_rd_blocked", req_ready, 0);
      if (rdy_now) n++;
    end
    @(negedge clk); wdata_v = '0; app_if.wdf_rdy = 1'b1;
    #1 chk("wr_done_idle", app_if.en, 0);
    @(negedge clk); #1;
    chk("wr_next_en", app_if.en, 1);
    chk("wr_next_ready", req_ready, 2'b01);
    chk("wr_next_addr", app_if.addr, 28'h600);

    // async reset in the middle of a write burst
    do_reset();
    req_v = 2'b01; req_cmd[0] = CMD_WR; req_addr[0] = 28'h700;
    @(negedge clk); #1 chk("ar_ready", req_ready, 2'b01);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req_v = '0; wdata_v = 2'b01; wdata[0] = 64'hE000 + 64'(b);
      #1 chk("ar_wren", app_if.wdf_wren, 1);
    end
    #1 rst = 1'b1;
    #1;
    chk("ar_wren_rst", app_if.wdf_wren, 0);
    chk("ar_wready_rst", wdata_ready, 0);
    chk("ar_wdata_rst", app_if.wdf_data, 0);
    chk("ar_en_rst", app_if.en, 0);
    @(negedge clk);
    rst = 1'b0; wdata_v = '0;
    req_v = 2'b11; req_cmd[0] = CMD_RD; req_cmd[1] = CMD_RD;
    req_addr[0] = 28'h800; req_addr[1] = 28'h900;
    #1 chk("ar_idle", app_if.en, 0);
    @(negedge clk); #1;
    chk("ar_first_en", app_if.en, 1);
    chk("ar_first_ready", req_ready, 2'b01);
    chk("ar_first_addr", app_if.addr, 28'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bsg_dmc_app_arbiter.md
Name: bsg_dmc_app_arbiter

Overview:
- Shares one bsg_dmc user (app_*) interface between num_req_p requesters, e.g. several memory tiles or NoC ports.
- Arbitration is round-robin at command granularity. A granted write keeps the grant until its full data burst has been transferred.
- Reads return in order from the controller. A read-tag FIFO routes each returned read burst to the requester that issued it.
- Sits in the ui_clk_i domain, directly upstream of the controller's app_* ports.

Parameters:
- num_req_p, 2, number of requesters (2..8)
- ui_addr_width_p, 28, app address width
- ui_data_width_p, 64, app data width
- ui_burst_length_p, 8, data beats per write or read burst (power of 2)
- rd_tag_depth_p, 4, outstanding-read capacity (power of 2)

Ports:
- ui_clk_i  in  1  user-interface clock
- ui_reset_i  in  1  asynchronous active-high reset
- req_v_i  in  N  command valid per requester
- req_cmd_i  in  3N  app command per requester (000 WR, 001 RD, 010 WP, 011 RP)
- req_addr_i  in  N*ui_addr_width_p  command address per requester
- req_ready_o  out  N  command accepted (one-hot, same cycle as transfer)
- req_wdata_v_i  in  N  write beat valid
- req_wdata_i  in  N*ui_data_width_p  write beat data
- req_wmask_i  in  N*(ui_data_width_p/8)  write beat mask
- req_wdata_ready_o  out  N  write beat accepted
- req_rdata_v_o  out  N  read beat valid, routed
- req_rdata_last_o  out  N  last read beat of burst, routed
- req_rdata_o  out  ui_data_width_p  read data, broadcast to all requesters
- app_addr_o, app_cmd_o, app_en_o  out  ui_addr_width_p/3/1  to controller
- app_rdy_i  in  1
- app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o  out  to controller
- app_wdf_rdy_i  in  1
- app_rd_data_i, app_rd_data_valid_i, app_rd_data_end_i  in  from controller
- init_calib_complete_i  in  1
- rd_unexpected_o  out  1  sticky error flag

Behaviour:
- Reset (async on ui_reset_i high):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, tag FIFO empty, rd_unexpected_o=0.
  - All *_o outputs are 0 during reset.
- Read/write decode: cmd[0]=1 is a read (RD, RP); cmd[0]=0 is a write (WR, WP). Commands 1xx are treated as RP.
- Eligibility: a requester is eligible if req_v_i is set, and, for a read, the tag FIFO is not full. Writes are never blocked by a full tag FIFO.
- IDLE:
  - If init_calib_complete_i=1 and any requester is eligible, select the first eligible index scanning from rr_ptr upward with wrap.
  - Register that index as grant; go to CMD. Arbitration takes 1 cycle.
- CMD:
  - app_en_o=1; app_cmd_o and app_addr_o are driven from req_*[grant].
  - On app_rdy_i=1: req_ready_o[grant]=1 combinationally, and rr_ptr=(grant+1) mod N.
  - Read: push grant into the tag FIFO, go to IDLE.
  - Write: beat_cnt=0, go to WDATA.
  - Requesters must hold req_v_i and command fields stable until ready.
- WDATA:
  - app_wdf_wren_o=req_wdata_v_i[grant]; req_wdata_ready_o[grant]=app_wdf_rdy_i.
  - app_wdf_data_o and app_wdf_mask_o come from req_*[grant].
  - app_wdf_end_o=(beat_cnt==ui_burst_length_p-1).
  - A beat transfers on wren&rdy; beat_cnt increments (width clog2(ui_burst_length_p), wraps to 0). The last beat returns the FSM to IDLE.
- Minimum back-to-back command spacing is 2 cycles (IDLE, CMD).
- Read return:
  - req_rdata_o=app_rd_data_i.
  - req_rdata_v_o[head]=app_rd_data_valid_i; req_rdata_last_o[head]=valid&end.
  - Pop on valid&end. Push and pop in the same cycle are legal; occupancy is unchanged.
- app_rd_data_valid_i with the tag FIFO empty: set rd_unexpected_o (sticky until reset); no requester valid is asserted.
- init_calib_complete_i falling mid-operation: the current command/burst completes; no new grant is made.
- Requesters are not backpressured on read data. A requester must always accept read beats.

Decomposition:
- Shared package bsg_dmc_pkg:
  - arbiter state enum (IDLE, CMD, WDATA);
  - command-encoding constants and the read-bit index.
- Sub-module bsg_dmc_rd_tag_fifo: synchronous FIFO of clog2(num_req_p)-bit tags, rd_tag_depth_p deep, with full/empty, async active-high reset.

Test Plan:
- Single read: req0 RD addr 0x100; app_rdy_i=1 -> app_en_o high for 1 cycle with app_cmd_o=001 and app_addr_o=0x100. Then 8 returned beats -> req_rdata_v_o=01 on each; req_rdata_last_o=01 on beat 8; tag FIFO empty afterwards.
- Fairness: req0 and req1 both holding RD continuously, app_rdy_i=1 -> grants alternate 0,1,0,1 over 4 commands.
- Write burst with stalls: req1 WR plus 8 beats, app_wdf_rdy_i low on beats 3 and 6 -> 8 transfers in total; app_wdf_end_o asserted only on beat 8; req0's pending RD is not granted until after beat 8.
- Tag full: 4 reads issued with no data returned -> a 5th RD is held with req_ready_o=0; a WR from another requester is still granted. After one burst returns, the 5th RD is accepted.
- Spurious data: app_rd_data_valid_i asserted with the tag FIFO empty -> rd_unexpected_o=1 and stays 1; req_rdata_v_o=0.
- Async reset in WDATA after 3 beats -> outputs 0 immediately; after release, state=IDLE and the first grant goes to req0.
